// File: rtl/apb_pkg.sv
// Shared APB slave definitions: FSM state encoding, lane-width helper, address-error decode.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } apb_state_t;

    // Number of byte-offset address bits for a given lane count (0 for a single lane).
    function automatic int SW_LOG2(input int sw);
        return (sw <= 1) ? 0 : $clog2(sw);
    endfunction

    // Flags an access that is misaligned or whose register index is past the bank.
    // Addresses are passed zero-extended to 64 bits so any slave width fits.
    function automatic logic apb_addr_err(input logic [63:0] addr,
                                          input int          nreg,
                                          input int          sw_log2 = 2);
        logic [63:0] mask;
        logic [63:0] idx;
        mask = (64'd1 << sw_log2) - 64'd1;
        idx  = addr >> sw_log2;
        return ((addr & mask) != 64'd0) || (idx >= 64'(nreg));
    endfunction

endpackage

// File: rtl/apb_wait_ctrl.sv
// APB transfer sequencer: tracks setup, counts wait states and raises pready for one cycle.
// Latency: pready registered, high WS+1 cycles after the setup edge.
// Backpressure: slave-driven wait states only; master abort (strobe drop) returns to IDLE.
module apb_wait_ctrl
    import apb_pkg::*;
#(
    parameter int WS = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic strb_i,
    input  logic penable_i,
    output logic setup_o,
    output logic load_o,
    output logic done_o,
    output logic abort_o,
    output logic pready_o
);

    apb_state_t state_q;
    logic [3:0] cnt_q;
    logic       pready_q;

    assign setup_o  = (state_q == IDLE) && strb_i && !penable_i;
    assign load_o   = (setup_o && (WS == 0)) ||
                      ((state_q == WAIT) && strb_i && (cnt_q == 4'd1));
    assign done_o   = (state_q == READY) && strb_i;
    assign abort_o  = (state_q != IDLE) && !strb_i;
    assign pready_o = pready_q;

    // Transfer FSM with wait counter; pready is loaded on entry to READY.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            pready_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    pready_q <= 1'b0;
                    if (strb_i && !penable_i) begin
                        if (WS == 0) begin
                            state_q  <= READY;
                            pready_q <= 1'b1;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= 4'(WS);
                        end
                    end
                end
                WAIT: begin
                    if (!strb_i) begin
                        state_q <= IDLE;
                        cnt_q   <= 4'd0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            state_q  <= READY;
                            pready_q <= 1'b1;
                        end
                    end
                end
                READY: begin
                    state_q  <= IDLE;
                    pready_q <= 1'b0;
                end
                default: begin
                    state_q  <= IDLE;
                    cnt_q    <= 4'd0;
                    pready_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/apb_reg_slave.sv
// APB register-bank endpoint: NREG byte-writable registers with per-register write pulses.
// Latency: WS+2 cycles per transfer; write visible on reg_q one cycle after completion.
// Backpressure: fixed WS wait states; master may abort by dropping apb_pstrb.
module apb_reg_slave
    import apb_pkg::*;
#(
    parameter int            AW      = 32,
    parameter int            DW      = 32,
    parameter int            SW      = DW / 8,
    parameter int            NREG    = 8,
    parameter int            WS      = 0,
    parameter logic [DW-1:0] RST_VAL = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               apb_pstrb,
    input  logic               apb_penable,
    input  logic               apb_pwrite,
    input  logic [AW-1:0]      apb_paddr,
    input  logic [SW-1:0]      apb_psel,
    input  logic [DW-1:0]      apb_pwdata,
    output logic [DW-1:0]      apb_prdata,
    output logic               apb_pready,
    output logic               apb_pslverr,
    output logic [NREG*DW-1:0] reg_q,
    output logic [NREG-1:0]    reg_we
);

    localparam int SWL = SW_LOG2(SW);
    localparam int IW  = (NREG > 1) ? $clog2(NREG) : 1;

    logic setup, load, done, abort;

    logic            wr_q, err_q;
    logic [IW-1:0]   idx_q;
    logic [SW-1:0]   psel_q;
    logic [DW-1:0]   wdata_q;

    logic            in_err;
    logic [IW-1:0]   in_idx;
    logic            cur_wr, cur_err;
    logic [IW-1:0]   cur_idx;

    logic [DW-1:0]   bank_q [NREG];
    logic [DW-1:0]   merged_d;
    logic [NREG-1:0] one_hot;
    logic [NREG-1:0] reg_we_q;
    logic [DW-1:0]   prdata_q;
    logic            pslverr_q;
    logic            commit;

    apb_wait_ctrl #(.WS(WS)) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .strb_i    (apb_pstrb),
        .penable_i (apb_penable),
        .setup_o   (setup),
        .load_o    (load),
        .done_o    (done),
        .abort_o   (abort),
        .pready_o  (apb_pready)
    );

    assign in_err = apb_addr_err(64'(apb_paddr), NREG, SWL);
    assign in_idx = apb_paddr[SWL +: IW];

    // With no wait states the response loads on the setup edge, before capture lands.
    assign cur_wr  = setup ? apb_pwrite : wr_q;
    assign cur_err = setup ? in_err     : err_q;
    assign cur_idx = setup ? in_idx     : idx_q;

    assign commit = done && wr_q && !err_q;

    // Capture the request at setup; held for the rest of the transfer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            psel_q  <= '0;
            wdata_q <= '0;
        end else if (setup) begin
            wr_q    <= apb_pwrite;
            err_q   <= in_err;
            idx_q   <= in_idx;
            psel_q  <= apb_psel;
            wdata_q <= apb_pwdata;
        end
    end

    // Merge enabled byte lanes of the write data over the current register value.
    always_comb begin
        merged_d = bank_q[idx_q];
        for (int b = 0; b < SW; b++) begin
            if (psel_q[b]) merged_d[8*b +: 8] = wdata_q[8*b +: 8];
        end
        one_hot        = '0;
        one_hot[idx_q] = 1'b1;
    end

    // Register bank update and write pulse, both on the completion edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) bank_q[i] <= RST_VAL;
            reg_we_q <= '0;
        end else begin
            reg_we_q <= '0;
            if (commit) begin
                bank_q[idx_q] <= merged_d;
                reg_we_q      <= one_hot;
            end
        end
    end

    // Response data/error are loaded entering READY and cleared on any other edge.
    always_ff @(posedge clk) begin
        if (!rst || !load || abort) begin
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
        end else begin
            pslverr_q <= cur_err;
            prdata_q  <= (cur_err || cur_wr) ? '0 : bank_q[cur_idx];
        end
    end

    assign apb_prdata  = prdata_q;
    assign apb_pslverr = pslverr_q;
    assign reg_we      = reg_we_q;

    for (genvar i = 0; i < NREG; i++) begin : g_flat
        assign reg_q[i*DW +: DW] = bank_q[i];
    end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench for apb_reg_slave: three instances at WS = 0, 3 and 4.
// Latency: checks pready lands in access cycle WS+1 and reg_we/reg_q one cycle after.
// Backpressure: exercises wait states, master abort and reset mid-transfer.
module tb_apb_reg_slave;

    localparam int ND = 3;

    function automatic int wsv(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 3 : 4);
    endfunction

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  ps;
        logic [31:0] wd;
        logic [31:0] exp;
        logic        err;
        logic [7:0]  we;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        pstrb   [ND];
    logic        penable [ND];
    logic        pwrite  [ND];
    logic [31:0] paddr   [ND];
    logic [3:0]  psel    [ND];
    logic [31:0] pwdata  [ND];
    logic [31:0] prdata  [ND];
    logic        pready  [ND];
    logic        pslverr [ND];
    logic [255:0] regq   [ND];
    logic [7:0]  we      [ND];

    int n_pass = 0;
    int n_tot  = 0;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        apb_reg_slave #(.WS(wsv(g))) u_dut (
            .clk         (clk),
            .rst         (rst),
            .apb_pstrb   (pstrb[g]),
            .apb_penable (penable[g]),
            .apb_pwrite  (pwrite[g]),
            .apb_paddr   (paddr[g]),
            .apb_psel    (psel[g]),
            .apb_pwdata  (pwdata[g]),
            .apb_prdata  (prdata[g]),
            .apb_pready  (pready[g]),
            .apb_pslverr (pslverr[g]),
            .reg_q       (regq[g]),
            .reg_we      (we[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    endtask

    // Full transfer; must be entered just after a rising edge and returns just after one.
    task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                        input logic [3:0] ps, input logic [31:0] wd,
                        input logic [31:0] exp, input logic exp_err, input logic [7:0] exp_we);
        int k;
        bit seen;
        pstrb[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
        paddr[d] = addr; psel[d] = ps; pwdata[d] = wd;
        @(negedge clk);
        chk("setup_pready", 64'(pready[d]), 64'd0);
        @(posedge clk); #1;
        penable[d] = 1'b1;
        seen = 1'b0;
        k = 0;
        while (!seen && k < 20) begin
            k++;
            @(negedge clk);
            if (pready[d]) begin
                seen = 1'b1;
                chk("pready_cycle", 64'(k), 64'(wsv(d) + 1));
                chk("pslverr", 64'(pslverr[d]), 64'(exp_err));
                if (!wr) chk("prdata", 64'(prdata[d]), 64'(exp));
            end else begin
                chk("quiet_wait", 64'({pslverr[d], prdata[d]}), 64'd0);
            end
            @(posedge clk); #1;
        end
        if (!seen) begin
            n_tot++;
            $display("FAIL pready_timeout: got no pready, required pready within %0d cycles", k);
        end
        pstrb[d] = 1'b0; penable[d] = 1'b0;
        chk("reg_we", 64'(we[d]), 64'(exp_we));
        if (wr && !exp_err) chk("reg_word", 64'(regq[d][int'(addr[4:2])*32 +: 32]), 64'(exp));
    endtask

    vec_t vt [15];

    initial begin
        rst = 1'b0;
        for (int d = 0; d < ND; d++) begin
            pstrb[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
            paddr[d] = '0; psel[d] = '0; pwdata[d] = '0;
        end

        vt[0]  = '{1'b1, 32'h0000_0004, 4'hF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 8'h02};
        vt[1]  = '{1'b0, 32'h0000_0004, 4'h0, 32'h0,         32'hDEAD_BEEF, 1'b0, 8'h00};
        vt[2]  = '{1'b0, 32'h0000_0020, 4'h0, 32'h0,         32'h0,         1'b1, 8'h00};
        vt[3]  = '{1'b1, 32'h0000_0006, 4'hF, 32'hFFFF_FFFF, 32'h0,         1'b1, 8'h00};
        vt[4]  = '{1'b0, 32'h0000_0004, 4'h0, 32'h0,         32'hDEAD_BEEF, 1'b0, 8'h00};
        vt[5]  = '{1'b1, 32'h0000_001C, 4'h8, 32'hAABB_CCDD, 32'hAA00_0000, 1'b0, 8'h80};
        vt[6]  = '{1'b0, 32'h0000_001C, 4'h0, 32'h0,         32'hAA00_0000, 1'b0, 8'h00};
        vt[7]  = '{1'b0, 32'h0000_001D, 4'h0, 32'h0,         32'h0,         1'b1, 8'h00};
        vt[8]  = '{1'b1, 32'h0000_0000, 4'h0, 32'h1234_5678, 32'h0,         1'b0, 8'h01};
        vt[9]  = '{1'b0, 32'h0000_0000, 4'h0, 32'h0,         32'h0,         1'b0, 8'h00};
        vt[10] = '{1'b1, 32'h0000_0100, 4'hF, 32'h5A5A_5A5A, 32'h0,         1'b1, 8'h00};
        vt[11] = '{1'b0, 32'hFFFF_FFFC, 4'h0, 32'h0,         32'h0,         1'b1, 8'h00};
        vt[12] = '{1'b1, 32'h0000_0008, 4'h3, 32'hCAFE_F00D, 32'h0000_F00D, 1'b0, 8'h04};
        vt[13] = '{1'b0, 32'h0000_0008, 4'hF, 32'h0,         32'h0000_F00D, 1'b0, 8'h00};
        vt[14] = '{1'b0, 32'h0000_0006, 4'h0, 32'h0,         32'h0,         1'b1, 8'h00};

        // Reset values of every instance.
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            chk("rst_pready",  64'(pready[d]),  64'd0);
            chk("rst_pslverr", 64'(pslverr[d]), 64'd0);
            chk("rst_prdata",  64'(prdata[d]),  64'd0);
            chk("rst_reg_we",  64'(we[d]),      64'd0);
            chk("rst_reg_q",   64'(regq[d] != 256'd0), 64'd0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Table of back-to-back transfers on the zero-wait-state instance.
        for (int i = 0; i < 15; i++)
            xfer(0, vt[i].wr, vt[i].addr, vt[i].ps, vt[i].wd, vt[i].exp, vt[i].err, vt[i].we);

        // penable asserted without a setup phase is ignored.
        pstrb[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1;
        paddr[0] = 32'h0000_0008; psel[0] = 4'hF; pwdata[0] = 32'h0BAD_0BAD;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("viol_pready", 64'(pready[0]), 64'd0);
            chk("viol_reg_we", 64'(we[0]),     64'd0);
        end
        @(posedge clk); #1;
        pstrb[0] = 1'b0; penable[0] = 1'b0;
        @(negedge clk);
        chk("viol_reg_word", 64'(regq[0][2*32 +: 32]), 64'h0000_F00D);
        @(posedge clk); #1;

        // Three wait states, partial-lane write onto a reset register.
        xfer(1, 1'b1, 32'h4, 4'b0101, 32'h1122_3344, 32'h0022_0044, 1'b0, 8'h02);
        xfer(1, 1'b0, 32'h4, 4'h0,    32'h0,         32'h0022_0044, 1'b0, 8'h00);

        // Master abort after two access cycles of a write with four wait states.
        xfer(2, 1'b1, 32'hC, 4'hF, 32'h0102_0304, 32'h0102_0304, 1'b0, 8'h08);
        pstrb[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1;
        paddr[2] = 32'hC; psel[2] = 4'hF; pwdata[2] = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        penable[2] = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("abort_pready_acc", 64'(pready[2]), 64'd0);
            @(posedge clk); #1;
        end
        pstrb[2] = 1'b0; penable[2] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("abort_pready", 64'(pready[2]), 64'd0);
            chk("abort_reg_we", 64'(we[2]),     64'd0);
        end
        chk("abort_reg_word", 64'(regq[2][3*32 +: 32]), 64'h0102_0304);
        @(posedge clk); #1;
        xfer(2, 1'b0, 32'hC, 4'h0, 32'h0, 32'h0102_0304, 1'b0, 8'h00);

        // Reset while a write sits in WAIT.
        xfer(1, 1'b1, 32'h0, 4'hF, 32'h0000_0055, 32'h0000_0055, 1'b0, 8'h01);
        pstrb[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = 32'h8; psel[1] = 4'hF; pwdata[1] = 32'h0000_0077;
        @(posedge clk); #1;
        penable[1] = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; pstrb[1] = 1'b0; penable[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_pready",  64'(pready[1]),  64'd0);
        chk("mrst_pslverr", 64'(pslverr[1]), 64'd0);
        chk("mrst_prdata",  64'(prdata[1]),  64'd0);
        chk("mrst_reg_we",  64'(we[1]),      64'd0);
        chk("mrst_reg0",    64'(regq[1][0 +: 32]), 64'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("mrst_late_we",   64'(we[1]),             64'd0);
            chk("mrst_late_reg2", 64'(regq[1][64 +: 32]), 64'd0);
        end
        @(posedge clk); #1;

        // Back-to-back write/read pairs over every register, no idle cycles.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) begin
                logic [31:0] dat;
                logic [7:0]  oh;
                dat = {8'(i + 1), 8'(d), 8'hC3, 8'(i * 17)};
                oh  = 8'd1 << i;
                xfer(d, 1'b1, 32'(i * 4), 4'hF, dat, dat, 1'b0, oh);
                xfer(d, 1'b0, 32'(i * 4), 4'h0, 32'h0, dat, 1'b0, 8'h00);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
